// File: rtl/mod_counter_pkg.sv
// ============================================================================
//  Module   : mod_counter_pkg
//  Purpose  : Shared direction constants and load-clamp helper for mod_counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

   localparam logic CNT_DOWN = 1'b0;
   localparam logic CNT_UP   = 1'b1;

   // Out-of-range load values park at the top of the count range.
   function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                              input logic [63:0] modulus);
      logic [63:0] top;
      top = modulus - 64'd1;
      return (value > top) ? top : value;
   endfunction

endpackage : mod_counter_pkg

`default_nettype wire

// File: rtl/mod_counter_next.sv
// ============================================================================
//  Module   : mod_counter_next
//  Purpose  : Combinational next-count and wrap-detect logic for mod_counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_next
   import mod_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 8,
   parameter longint unsigned MODULUS = longint'(1) << WIDTH
) (
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] next,
   output logic             wrap_next
);

   localparam logic [WIDTH:0] C_MAX  = (WIDTH+1)'(MODULUS - 64'd1);
   localparam logic [WIDTH:0] C_ONE  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] C_ZERO = '0;

   logic [WIDTH:0] w_count_ext;
   logic [WIDTH:0] w_inc;
   logic [WIDTH:0] w_dec;
   logic           w_at_max;
   logic           w_at_zero;

   // One guard bit keeps the +1/-1 arithmetic free of register overflow.
   assign w_count_ext = {1'b0, count};
   assign w_inc       = w_count_ext + C_ONE;
   assign w_dec       = w_count_ext - C_ONE;
   assign w_at_max    = (w_count_ext == C_MAX);
   assign w_at_zero   = (w_count_ext == C_ZERO);

   always_comb begin
      next      = count;
      wrap_next = 1'b0;
      if (en) begin
         if (up == CNT_UP) begin
            if (!w_at_max) begin
               next = w_inc[WIDTH-1:0];
            end else if (!sat) begin
               next      = '0;
               wrap_next = 1'b1;
            end
         end else begin
            if (!w_at_zero) begin
               next = w_dec[WIDTH-1:0];
            end else if (!sat) begin
               next      = C_MAX[WIDTH-1:0];
               wrap_next = 1'b1;
            end
         end
      end
   end

endmodule : mod_counter_next

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Up/down modulo-N counter with clear, clamped load, terminal
//             count and registered wrap pulse. Define COUNTER_SAT_EN to add
//             the sat port (saturate instead of wrap).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 8,
   parameter longint unsigned MODULUS = longint'(1) << WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [63:0]    C_MODULUS = 64'(MODULUS);
   localparam logic [WIDTH:0] C_MAX     = (WIDTH+1)'(MODULUS - 64'd1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap_next;
   logic [WIDTH-1:0] w_load_val;
   logic             w_sat;

`ifdef COUNTER_SAT_EN
   assign w_sat = sat;
`else
   assign w_sat = 1'b0;
`endif

   mod_counter_next #(
      .WIDTH     (WIDTH),
      .MODULUS   (MODULUS)
   ) u_next (
      .count     (count_q),
      .en        (en),
      .up        (up),
      .sat       (w_sat),
      .next      (w_next),
      .wrap_next (w_wrap_next)
   );

   assign w_load_val = WIDTH'(clamp_load(64'(load_val), C_MODULUS));

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = w_load_val;
      end else begin
         count_d = w_next;
         wrap_d  = w_wrap_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // Terminal count is combinational so a cascaded stage steps on the same edge.
   assign tc    = en & ((up == CNT_UP) ? ({1'b0, count_q} == C_MAX)
                                       : (count_q == '0));
   assign count = count_q;
   assign wrap  = wrap_q;

endmodule : mod_counter

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
//  Module   : tb_mod_counter
//  Purpose  : Directed self-checking bench for mod_counter (MODULUS=10).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       sat = 1'b0;
   logic [3:0] count;
   logic       tc;
   logic       wrap;

   logic       c_en = 1'b0;
   logic       c_up = 1'b1;
   logic       c_zero = 1'b0;
   logic [3:0] c_lv = '0;
   logic [3:0] lo_cnt;
   logic [3:0] hi_cnt;
   logic       lo_tc;
   logic       hi_tc;
   logic       lo_wrap;
   logic       hi_wrap;

   int n_checks = 0;
   int n_fail   = 0;
   int hi_wraps = 0;
   int lo_wraps = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
`ifdef COUNTER_SAT_EN
      .sat      (sat),
`endif
      .count    (count),
      .tc       (tc),
      .wrap     (wrap)
   );

   mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (c_en),
      .up       (c_up),
      .clr      (c_zero),
      .load     (c_zero),
      .load_val (c_lv),
`ifdef COUNTER_SAT_EN
      .sat      (c_zero),
`endif
      .count    (lo_cnt),
      .tc       (lo_tc),
      .wrap     (lo_wrap)
   );

   mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (lo_tc),
      .up       (c_up),
      .clr      (c_zero),
      .load     (c_zero),
      .load_val (c_lv),
`ifdef COUNTER_SAT_EN
      .sat      (c_zero),
`endif
      .count    (hi_cnt),
      .tc       (hi_tc),
      .wrap     (hi_wrap)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] v);
      load = 1'b1; load_val = v; en = 1'b0;
      step();
      load = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      chk("rst_count", 32'(count), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_tc_en0", 32'(tc), 0);
      en = 1'b1; up = 1'b0; #1;
      chk("rst_tc_down", 32'(tc), 1);
      en = 1'b0; up = 1'b1;
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle from count 7
      do_load(4'd7);
      chk("load7", 32'(count), 7);
      en = 1'b1; up = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_wrap", 32'(wrap), 0);
      #1 rst_n = 1'b1;
      step(); chk("post_rst_1", 32'(count), 1);
      step(); chk("post_rst_2", 32'(count), 2);
      step(); chk("post_rst_3", 32'(count), 3);

      // Up wrap
      do_load(4'd8);
      en = 1'b1; up = 1'b1; #1;
      chk("tc_at8", 32'(tc), 0);
      step(); chk("up_9", 32'(count), 9); chk("up_tc9", 32'(tc), 1); chk("up_wrap9", 32'(wrap), 0);
      step(); chk("up_0", 32'(count), 0); chk("up_wrap0", 32'(wrap), 1); chk("up_tc0", 32'(tc), 0);
      step(); chk("up_1", 32'(count), 1); chk("up_wrap1", 32'(wrap), 0);

      // Down wrap
      up = 1'b0;
      step(); chk("dn_0", 32'(count), 0); chk("dn_tc0", 32'(tc), 1); chk("dn_wrap0", 32'(wrap), 0);
      step(); chk("dn_9", 32'(count), 9); chk("dn_wrap9", 32'(wrap), 1);
      step(); chk("dn_8", 32'(count), 8); chk("dn_wrap8", 32'(wrap), 0);

      // Priority and clamp
      do_load(4'd3);
      clr = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1; up = 1'b1;
      step(); chk("clr_wins", 32'(count), 0); chk("clr_wrap", 32'(wrap), 0);
      clr = 1'b0; en = 1'b0;
      step(); chk("load5", 32'(count), 5);
      load_val = 4'd12;
      step(); chk("load_clamp12", 32'(count), 9);
      load_val = 4'd15;
      step(); chk("load_clamp15", 32'(count), 9);
      load_val = 4'd9; en = 1'b1; up = 1'b1;
      step(); chk("load_over_en", 32'(count), 9); chk("load_no_wrap", 32'(wrap), 0);
      load = 1'b0; en = 1'b0;
      step(); chk("hold", 32'(count), 9);

      // tc follows direction in the same cycle
      en = 1'b1; up = 1'b1; #1;
      chk("tc_dir_up", 32'(tc), 1);
      up = 1'b0; #1;
      chk("tc_dir_dn", 32'(tc), 0);
      en = 1'b0;

`ifdef COUNTER_SAT_EN
      do_load(4'd8);
      sat = 1'b1; en = 1'b1; up = 1'b1;
      step(); chk("sat_9", 32'(count), 9);
      step(); chk("sat_hold9", 32'(count), 9); chk("sat_wrap", 32'(wrap), 0); chk("sat_tc", 32'(tc), 1);
      up = 1'b0;
      step(); chk("sat_dn8", 32'(count), 8);
      do_load(4'd0);
      en = 1'b1; up = 1'b0;
      step(); chk("sat_hold0", 32'(count), 0); chk("sat_wrap0", 32'(wrap), 0); chk("sat_tc0", 32'(tc), 1);
      sat = 1'b0; en = 1'b0;
`endif

      // Two-stage cascade, both stages idle at 0 since reset
      chk("casc_start_lo", 32'(lo_cnt), 0);
      chk("casc_start_hi", 32'(hi_cnt), 0);
      c_en = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (hi_wrap) hi_wraps++;
         if (lo_wrap) lo_wraps++;
         if (i == 57) begin
            chk("casc57_lo", 32'(lo_cnt), 7);
            chk("casc57_hi", 32'(hi_cnt), 5);
         end
      end
      c_en = 1'b0;
      chk("casc_lo", 32'(lo_cnt), 0);
      chk("casc_hi", 32'(hi_cnt), 0);
      chk("casc_hi_wraps", 32'(hi_wraps), 1);
      chk("casc_lo_wraps", 32'(lo_wraps), 10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mod_counter

`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo-N counter: the general-purpose successor to the fixed 4-bit up counter. It adds configurable width and modulus, count enable, direction control, synchronous clear and load, and a terminal-count output for cascading. A registered wrap pulse is also provided. It sits wherever the design needs event counting, timers, prescalers or cascaded multi-digit counters.

## Interface
- WIDTH, default 8: counter register width in bits; must be ≥ 1.
- MODULUS, default 2**WIDTH: count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value applied on load.
- sat  input  1  saturate mode; present only with COUNTER_SAT_EN.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational: en & (up ? count==MODULUS-1 : count==0).
- wrap  output  1  registered one-cycle pulse, high the cycle after count wraps.

## Operation
- Reset: rst_n low forces count=0 and wrap=0 immediately, without waiting for a clock edge. tc then follows its equation, so it is 1 if en=1 and up=0.
- Per-edge priority is clr > load > en > hold.
- clr=1: count←0; wrap←0.
- load=1 (clr=0): count←load_val if load_val ≤ MODULUS-1, else count←MODULUS-1 (clamped); wrap←0.
- en=1 with up=1: count←count+1, or 0 if count==MODULUS-1.
- en=1 with up=0: count←count-1, or MODULUS-1 if count==0.
- wrap←1 only on an en step that crosses the boundary in either direction; otherwise wrap←0.
- en=0 (no clr or load): count holds; wrap←0.
- Arithmetic: computed in WIDTH+1 bits internally; no overflow of the register is possible.
- Cascading: an upper stage's en is driven from the lower stage's tc; the two stages step on the same edge.

## Timing
- Latency from control to count is 1 cycle: control sampled at edge N appears on count after edge N.
- tc is 0-cycle (combinational from count, en, up); a direction change takes effect on tc in the same cycle.
- wrap is asserted for exactly one cycle, aligned with the wrapped count value.
- Reset deassertion: the first count step occurs on the first rising edge with rst_n=1 and en=1. A synchroniser is not part of this block.
- Reset mid-operation: count=0 and wrap=0 asynchronously; any in-flight load is discarded.

## Configuration
- COUNTER_SAT_EN defined: the sat port exists.
  - With sat=1, the counter stops at MODULUS-1 (up) or 0 (down) instead of wrapping.
  - wrap stays 0 in saturate mode; tc remains asserted while parked at the limit with en=1.
- COUNTER_SAT_EN undefined: no sat port; the counter always wraps.

## Structure
- Shared package mod_counter_pkg holds:
  - the direction constants CNT_DOWN=1'b0 and CNT_UP=1'b1;
  - the function clamp_load(value, modulus) used by the load path.
- One sub-module, mod_counter_next: purely combinational next-state and wrap-detect logic (inputs count, en, up, sat; outputs next, wrap_next).
- The top level holds the count and wrap registers plus the clr/load priority mux.

## Test plan
- Reset: WIDTH=4, MODULUS=10, counting at 7; pull rst_n low between edges → count=0 and wrap=0 immediately. Release, en=1, up=1 → 1,2,3 on successive edges.
- Up wrap: MODULUS=10, en=1, up=1 from 8 → count 9 (tc=1), then 0 with wrap=1 for one cycle, then 1 with wrap=0.
- Down wrap: from 1 with up=0 → 0 (tc=1), then 9 with wrap=1.
- Priority: clr=1, load=1, load_val=5, en=1 at count=3 → 0. Next cycle load=1 only → 5. Then load_val=12 → clamped to 9.
- Cascade: two MODULUS=10 instances, the upper stage's en tied to the lower stage's tc. After 100 enabled cycles from 0 → both stages read 0 and the upper stage's wrap pulses once.
- Saturate (COUNTER_SAT_EN, sat=1): up from 8 → 9, then holds at 9 with wrap=0 and tc=1. Then up=0 → 8.
